pic_prog_loader: RTL and testbench

- Byte-stream bootloader that writes 14-bit instruction words into the 2048-word program memory that the CPU fetches from. It is the writer end of the program-ROM fetch path.
- Receives framed bytes from a host link (UART RX or testbench) over a valid/ready handshake.
- Assembles instruction words and issues single-cycle writes to the program memory.
- Holds the CPU in reset until a frame loads with a correct checksum.

---
 rtl/pic_prog_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_pic_prog_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_prog_loader.sv
// Byte-stream bootloader: parses SYNC/count/word-pair/checksum frames from a host link
// and writes 14-bit instruction words into program memory, holding the CPU in reset until a good load.
module pic_prog_loader #(
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_data is ignored otherwise and the producer holds the byte until taken.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNT_H = 3'd1,
        S_CNT_L = 3'd2,
        S_W_HI  = 3'd3,
        S_W_LO  = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                prog_we_q, prog_we_d;
    logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0]   prog_wdata_q, prog_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [7:0]          xor_q, xor_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [2:0]          cnt_h_q, cnt_h_d;
    logic [5:0]          hi_q, hi_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                xfer;
    logic [ADDR_W-1:0]   n_new;

    assign xfer  = in_valid && in_ready_q;
    assign n_new = ADDR_W'({cnt_h_q, in_data});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            prog_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            words_q      <= '0;
            xor_q        <= 8'd0;
            idx_q        <= '0;
            n_q          <= '0;
            cnt_h_q      <= 3'd0;
            hi_q         <= 6'd0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            prog_we_q    <= prog_we_d;
            prog_addr_q  <= prog_addr_d;
            prog_wdata_q <= prog_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            words_q      <= words_d;
            xor_q        <= xor_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            cnt_h_q      <= cnt_h_d;
            hi_q         <= hi_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prog_we_d    = 1'b0;
        prog_addr_d  = prog_addr_q;
        prog_wdata_d = prog_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        err_code_d   = err_code_q;
        words_d      = words_q;
        xor_d        = xor_q;
        idx_d        = idx_q;
        n_d          = n_q;
        cnt_h_d      = cnt_h_q;
        hi_d         = hi_q;
        tmo_d        = tmo_q;

        // Inter-byte timeout inside a frame; a byte on the expiry cycle wins.
        if (state_q inside {S_CNT_H, S_CNT_L, S_W_HI, S_W_LO, S_CHK}) begin
            if (xfer) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d      = '0;
                err_code_d = 2'd3;
                state_d    = S_ERR;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    cpu_hold_d = 1'b1;
                    err_code_d = 2'd0;
                    words_d    = '0;
                    xor_d      = 8'd0;
                    idx_d      = '0;
                    tmo_d      = '0;
                    state_d    = S_CNT_H;
                end
            end
            S_CNT_H: begin
                if (xfer) begin
                    xor_d   = xor_q ^ in_data;
                    cnt_h_d = in_data[2:0];
                    if (in_data[7:3] != 5'd0) begin
                        err_code_d = 2'd0;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_CNT_L;
                    end
                end
            end
            S_CNT_L: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    n_d   = n_new;
                    if (n_new == '0) begin
                        err_code_d = 2'd0;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_W_HI;
                    end
                end
            end
            S_W_HI: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    hi_d  = in_data[5:0];
                    if (in_data[7:6] != 2'd0) begin
                        err_code_d = 2'd1;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (xfer) begin
                    xor_d        = xor_q ^ in_data;
                    prog_we_d    = 1'b1;
                    prog_addr_d  = idx_q;
                    prog_wdata_d = DATA_W'({hi_q, in_data});
                    idx_d        = idx_q + 1'b1;
                    words_d      = words_q + 1'b1;
                    state_d      = (idx_q + 1'b1 == n_q) ? S_CHK : S_W_HI;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == xor_q) begin
                        state_d = S_DONE;
                    end else begin
                        err_code_d = 2'd2;
                        state_d    = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered pulses and ready track the state being entered.
        in_ready_d = !(state_d inside {S_DONE, S_ERR});
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        if (state_d == S_DONE) cpu_hold_d = 1'b0;
    end

    assign in_ready     = in_ready_q;
    assign prog_we      = prog_we_q;
    assign prog_addr    = prog_addr_q;
    assign prog_wdata   = prog_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
// Directed bench for pic_prog_loader: framing, checksum, error codes, timeout edge and reset.
module tb_pic_prog_loader;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 14;
    localparam int TMO    = 1000;
    localparam int WR_W   = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [WR_W-1:0] got_q[$];
    logic [WR_W-1:0] exp_q[$];
    logic [7:0]      tx_q[$];

    pic_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .err_code(err_code), .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_we) got_q.push_back({prog_addr, prog_wdata});
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL ready_wait: in_ready stayed %0b for byte %02h, required 1", in_ready, b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_tx();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({in_ready, prog_we, done, err} !== 4'b0000) begin errors++;
            $display("FAIL rst_ctrl: ready/we/done/err=%b required 0000", {in_ready, prog_we, done, err}); end
        checks++; if (cpu_hold !== 1'b1) begin errors++;
            $display("FAIL rst_hold: got %b required 1", cpu_hold); end
        checks++; if ({prog_addr, prog_wdata, err_code, words_loaded} !== '0) begin errors++;
            $display("FAIL rst_data: addr=%0h wdata=%0h code=%0d words=%0d required 0", prog_addr, prog_wdata, err_code, words_loaded); end
        checks++; if (dbg_state !== 3'd0) begin errors++;
            $display("FAIL rst_state: got %0d required 0", dbg_state); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready_after: got %b required 1", in_ready); end
    endtask

    task automatic test_good_frame();
        clear_obs();
        exp_q = '{{11'd0, 14'h3005}, {11'd1, 14'h008D}};
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h00, 8'h8D, 8'hBA};
        send_tx();
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++;
            $display("FAIL good_done_edge: done=%b hold=%b required 1/0", done, cpu_hold); end
        idle(3);
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL good_wr_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++;
            $display("FAIL good_wr%0d: got %h required %h", i, got_q[i], exp_q[i]); end end
        checks++; if (words_loaded !== 12'd2) begin errors++;
            $display("FAIL good_words: got %0d required 2", words_loaded); end
        checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++;
            $display("FAIL good_pulses: done=%0d err=%0d required 1/0", done_cnt, err_cnt); end
        checks++; if (cpu_hold !== 1'b0) begin errors++;
            $display("FAIL good_hold: got %b required 0", cpu_hold); end
    endtask

    task automatic test_bad_chk();
        clear_obs();
        exp_q = '{{11'd0, 14'h3005}, {11'd1, 14'h008D}};
        send_byte(8'hA5);
        checks++; if (cpu_hold !== 1'b1) begin errors++;
            $display("FAIL reload_hold: got %b required 1", cpu_hold); end
        tx_q = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h00, 8'h8D, 8'hBB};
        send_tx();
        idle(3);
        checks++; if (got_q.size() != exp_q.size()) begin errors++;
            $display("FAIL badchk_wr_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin checks++; if (got_q[i] !== exp_q[i]) begin errors++;
            $display("FAIL badchk_wr%0d: got %h required %h", i, got_q[i], exp_q[i]); end end
        checks++; if (err_cnt != 1 || done_cnt != 0) begin errors++;
            $display("FAIL badchk_pulses: err=%0d done=%0d required 1/0", err_cnt, done_cnt); end
        checks++; if (err_code !== 2'd2 || cpu_hold !== 1'b1) begin errors++;
            $display("FAIL badchk_code: code=%0d hold=%b required 2/1", err_code, cpu_hold); end
    endtask

    task automatic test_bad_count();
        clear_obs();
        tx_q = '{8'hA5, 8'h00, 8'h00};
        send_tx();
        idle(3);
        checks++; if (err_cnt != 1 || err_code !== 2'd0 || got_q.size() != 0) begin errors++;
            $display("FAIL cnt_zero: err=%0d code=%0d writes=%0d required 1/0/0", err_cnt, err_code, got_q.size()); end
        clear_obs();
        tx_q = '{8'hA5, 8'h08, 8'h01};
        send_tx();
        idle(3);
        checks++; if (err_cnt != 1 || err_code !== 2'd0 || got_q.size() != 0) begin errors++;
            $display("FAIL cnt_high: err=%0d code=%0d writes=%0d required 1/0/0", err_cnt, err_code, got_q.size()); end
    endtask

    task automatic test_bad_hi();
        clear_obs();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h40, 8'h00};
        send_tx();
        idle(3);
        checks++; if (err_cnt != 1 || err_code !== 2'd1 || got_q.size() != 0) begin errors++;
            $display("FAIL bad_hi: err=%0d code=%0d writes=%0d required 1/1/0", err_cnt, err_code, got_q.size()); end
        checks++; if (words_loaded !== 12'd0) begin errors++;
            $display("FAIL bad_hi_words: got %0d required 0", words_loaded); end
    endtask

    task automatic test_timeout();
        int n;
        clear_obs();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h30};
        send_tx();
        n = 0;
        while (!err && n < TMO + 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != TMO) begin errors++;
            $display("FAIL tmo_cycle: err after %0d idle cycles required %0d", n, TMO); end
        checks++; if (err_code !== 2'd3 || got_q.size() != 0) begin errors++;
            $display("FAIL tmo_code: code=%0d writes=%0d required 3/0", err_code, got_q.size()); end
        idle(2);
    endtask

    task automatic test_timeout_race();
        clear_obs();
        exp_q = '{{11'd0, 14'h3005}};
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h30};
        send_tx();
        repeat (TMO - 1) @(posedge clk);
        tx_q = '{8'h05, 8'h34};
        send_tx();
        idle(3);
        checks++; if (err_cnt != 0 || done_cnt != 1) begin errors++;
            $display("FAIL tmo_race: err=%0d done=%0d required 0/1", err_cnt, done_cnt); end
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++;
            $display("FAIL tmo_race_wr: writes=%0d first=%h required 1/%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); end
    endtask

    task automatic test_garbage();
        clear_obs();
        exp_q = '{{11'd0, 14'h3005}, {11'd1, 14'h008D}};
        tx_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h00, 8'h8D, 8'hBA};
        send_tx();
        idle(3);
        checks++; if (done_cnt != 1 || err_cnt != 0 || cpu_hold !== 1'b0) begin errors++;
            $display("FAIL garbage: done=%0d err=%0d hold=%b required 1/0/0", done_cnt, err_cnt, cpu_hold); end
        checks++; if (got_q.size() != 2 || words_loaded !== 12'd2) begin errors++;
            $display("FAIL garbage_wr: writes=%0d words=%0d required 2/2", got_q.size(), words_loaded); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        exp_q = '{{11'd0, 14'h3005}};
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h00};
        send_tx();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (cpu_hold !== 1'b1 || dbg_state !== 3'd0 || words_loaded !== 12'd0) begin errors++;
            $display("FAIL mid_rst: hold=%b state=%0d words=%0d required 1/0/0", cpu_hold, dbg_state, words_loaded); end
        @(negedge clk);
        reset = 1'b0;
        tx_q = '{8'h8D, 8'hBA};
        send_tx();
        idle(3);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++;
            $display("FAIL mid_rst_wr: writes=%0d required 1 (%h)", got_q.size(), exp_q[0]); end
        checks++; if (done_cnt != 0 || cpu_hold !== 1'b1) begin errors++;
            $display("FAIL mid_rst_done: done=%0d hold=%b required 0/1", done_cnt, cpu_hold); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_bad_count();
        test_bad_hi();
        test_timeout();
        test_timeout_race();
        test_garbage();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
